// File: rtl/universal_register_r_pkg.sv
// Shared mode encodings for the universal register family.
package universal_register_r_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_UP   = 3'b100;
    localparam logic [2:0] MODE_DOWN = 3'b101;
    localparam logic [2:0] MODE_ROL  = 3'b110;
    localparam logic [2:0] MODE_ROR  = 3'b111;

endpackage

// File: rtl/universal_register_r_register_r.sv
// Plain WIDTH-bit D register with synchronous active-high reset to RESET_VAL.
module register_r #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) data_q <= RESET_VAL;
        else       data_q <= d;
    end

    assign q = data_q;

endmodule

// File: rtl/universal_register_r.sv
// WIDTH-bit register with load, shift, rotate and up/down count, plus
// registered serial-out and combinational terminal count for cascading.
module universal_register_r
    import universal_register_r_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             tc
);

    logic [WIDTH-1:0] q_d;
    logic             ser_out_d;

    always_comb begin
        q_d       = q;
        ser_out_d = ser_out;
        if (en) begin
            unique case (mode)
                MODE_HOLD: ;
                MODE_LOAD: q_d = d;
                MODE_SHL: begin
                    q_d       = {q[WIDTH-2:0], ser_in};
                    ser_out_d = q[WIDTH-1];
                end
                MODE_SHR: begin
                    q_d       = {ser_in, q[WIDTH-1:1]};
                    ser_out_d = q[0];
                end
                MODE_UP:   q_d = q + 1'b1;
                MODE_DOWN: q_d = q - 1'b1;
                MODE_ROL: begin
                    q_d       = {q[WIDTH-2:0], q[WIDTH-1]};
                    ser_out_d = q[WIDTH-1];
                end
                MODE_ROR: begin
                    q_d       = {q[0], q[WIDTH-1:1]};
                    ser_out_d = q[0];
                end
                default: ;
            endcase
        end
    end

    // tc flags the state just before the wrapping edge so an upper stage can enable on it
    assign tc = en & (((mode == MODE_UP)   & (q == {WIDTH{1'b1}})) |
                      ((mode == MODE_DOWN) & (q == {WIDTH{1'b0}})));

    register_r #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_q_reg (
        .clk   (clk),
        .reset (reset),
        .d     (q_d),
        .q     (q)
    );

    register_r #(.WIDTH(1), .RESET_VAL(1'b0)) u_ser_out_reg (
        .clk   (clk),
        .reset (reset),
        .d     (ser_out_d),
        .q     (ser_out)
    );

endmodule

// File: tb/tb_universal_register_r.sv
// Bench for universal_register_r: directed plan plus random stimulus vs. an arithmetic model.
module tb_universal_register_r;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [7:0] d = 8'd0;
    logic       ser_in = 1'b0;

    logic [7:0] q8;
    logic       so8, tc8;
    logic [2:0] q3;
    logic       so3, tc3;

    int checks = 0;
    int failures = 0;

    logic [31:0] m8_q, m3_q;
    logic        m8_so, m3_so;

    always #5 clk = ~clk;

    universal_register_r #(.WIDTH(8), .RESET_VAL(8'h00)) dut8 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d), .ser_in(ser_in),
        .q(q8), .ser_out(so8), .tc(tc8)
    );

    universal_register_r #(.WIDTH(3), .RESET_VAL(3'b101)) dut3 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d[2:0]), .ser_in(ser_in),
        .q(q3), .ser_out(so3), .tc(tc3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mask_of(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Next register value from the mode's arithmetic meaning.
    function automatic logic [31:0] nxt_q(input int w, input logic [31:0] cur, input logic [2:0] m,
                                          input logic [31:0] dv, input logic si);
        logic [31:0] mk, top;
        mk  = mask_of(w);
        top = 32'd1 << (w - 1);
        case (m)
            3'd0: return cur;
            3'd1: return dv & mk;
            3'd2: return ((cur * 2) + 32'(si)) & mk;
            3'd3: return (cur / 2) + (si ? top : 32'd0);
            3'd4: return (cur + 32'd1) & mk;
            3'd5: return (cur + mk) & mk;
            3'd6: return ((cur * 2) & mk) + ((cur >= top) ? 32'd1 : 32'd0);
            default: return (cur / 2) + ((cur % 2 == 1) ? top : 32'd0);
        endcase
    endfunction

    function automatic logic nxt_so(input int w, input logic [31:0] cur, input logic [2:0] m,
                                    input logic so);
        if (m == 3'd2 || m == 3'd6) return cur >= (32'd1 << (w - 1));
        if (m == 3'd3 || m == 3'd7) return cur % 2 == 1;
        return so;
    endfunction

    function automatic logic exp_tc(input int w, input logic [31:0] cur);
        if (!en) return 1'b0;
        if (mode == 3'd4) return cur == mask_of(w);
        if (mode == 3'd5) return cur == 32'd0;
        return 1'b0;
    endfunction

    // Apply one cycle of stimulus, advance the model, and compare everything after the edge.
    task automatic tick(input logic r, input logic e, input logic [2:0] m,
                        input logic [7:0] dv, input logic si);
        logic [31:0] n8, n3;
        logic        s8, s3;
        reset = r; en = e; mode = m; d = dv; ser_in = si;
        if (r) begin
            n8 = 32'h00; s8 = 1'b0;
            n3 = 32'h5;  s3 = 1'b0;
        end else if (!e) begin
            n8 = m8_q; s8 = m8_so;
            n3 = m3_q; s3 = m3_so;
        end else begin
            n8 = nxt_q(8, m8_q, m, 32'(dv), si);
            s8 = nxt_so(8, m8_q, m, m8_so);
            n3 = nxt_q(3, m3_q, m, 32'(dv[2:0]), si);
            s3 = nxt_so(3, m3_q, m, m3_so);
        end
        @(posedge clk);
        #1;
        m8_q = n8; m8_so = s8; m3_q = n3; m3_so = s3;
        chk("q8", 32'(q8), m8_q);
        chk("ser_out8", 32'(so8), 32'(m8_so));
        chk("tc8", 32'(tc8), 32'(exp_tc(8, m8_q)));
        chk("q3", 32'(q3), m3_q);
        chk("ser_out3", 32'(so3), 32'(m3_so));
        chk("tc3", 32'(tc3), 32'(exp_tc(3, m3_q)));
    endtask

    initial begin
        m8_q = 32'h0; m3_q = 32'h0; m8_so = 1'b0; m3_so = 1'b0;

        // reset and load
        tick(1, 0, 3'd0, 8'h00, 0);
        tick(1, 1, 3'd1, 8'h5A, 1);
        chk("reset_q8", 32'(q8), 32'h00);
        chk("reset_q3", 32'(q3), 32'h5);
        tick(0, 1, 3'd1, 8'hA5, 0);
        chk("load_a5", 32'(q8), 32'hA5);

        // count up wrap
        tick(0, 1, 3'd1, 8'hFE, 0);
        tick(0, 1, 3'd4, 8'h00, 0);
        chk("tc_at_ff", 32'(tc8), 32'h1);
        tick(0, 1, 3'd4, 8'h00, 0);
        chk("up_wrap", 32'(q8), 32'h00);
        tick(0, 1, 3'd4, 8'h00, 0);

        // count down wrap
        tick(0, 1, 3'd1, 8'h01, 0);
        tick(0, 1, 3'd5, 8'h00, 0);
        chk("tc_at_00", 32'(tc8), 32'h1);
        tick(0, 1, 3'd5, 8'h00, 0);
        chk("down_wrap", 32'(q8), 32'hFF);

        // shifts
        tick(0, 1, 3'd1, 8'h81, 0);
        tick(0, 1, 3'd2, 8'h00, 1);
        chk("shl1", {23'd0, so8, q8}, {23'd0, 1'b1, 8'h03});
        tick(0, 1, 3'd2, 8'h00, 1);
        chk("shl2", {23'd0, so8, q8}, {23'd0, 1'b0, 8'h07});
        tick(0, 1, 3'd3, 8'h00, 0);
        chk("shr1", {23'd0, so8, q8}, {23'd0, 1'b1, 8'h03});

        // rotates
        tick(0, 1, 3'd1, 8'h81, 0);
        tick(0, 1, 3'd7, 8'h00, 0);
        chk("ror", {23'd0, so8, q8}, {23'd0, 1'b1, 8'hC0});
        tick(0, 1, 3'd6, 8'h00, 0);
        chk("rol", 32'(q8), 32'h81);

        // enable and priority
        tick(0, 1, 3'd1, 8'h10, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 3'd4, 8'h00, 0);
        chk("en0_hold", 32'(q8), 32'h10);
        chk("en0_tc", 32'(tc8), 32'h0);
        tick(1, 1, 3'd1, 8'hFF, 0);
        chk("reset_over_load", 32'(q8), 32'h00);

        // narrow instance count
        tick(0, 1, 3'd4, 8'h00, 0);
        chk("w3_up1", 32'(q3), 32'h6);
        tick(0, 1, 3'd4, 8'h00, 0);
        chk("w3_tc", 32'(tc3), 32'h1);
        tick(0, 1, 3'd4, 8'h00, 0);
        chk("w3_wrap", 32'(q3), 32'h0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
